sram_1rw_mask_ext: RTL



---
 rtl/sram_1rw_mask_ext.sv | 119 +++++++++++
 1 files changed

// File: rtl/sram_1rw_mask_ext.sv
// sram_1rw_mask_ext: single-port memory with lane write masks, a registered
// read port that holds its value between reads, and an optional sweep that
// zeroes the array after reset before any access is accepted.
module sram_1rw_mask_ext #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int MASK_WIDTH     = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  RW0_clk,
  input  logic                  RW0_reset,
  input  logic [ADDR_WIDTH-1:0] RW0_addr,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  input  logic [MASK_WIDTH-1:0] RW0_wmask,
  input  logic [DATA_WIDTH-1:0] RW0_wdata,
  output logic [DATA_WIDTH-1:0] RW0_rdata,
  output logic                  RW0_ready
);

  localparam int LANE_WIDTH = DATA_WIDTH / MASK_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   clr_addr_reg, clr_addr_next;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [MASK_WIDTH-1:0]   wr_mask;
  logic                    rd_en;

  // Next-state logic: the sweep counter advances every CLEAR cycle and the
  // FSM leaves CLEAR on the cycle that writes the last word.
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      ST_CLEAR: begin
        clr_addr_next = clr_addr_reg + ADDR_ONE;
        if (clr_addr_reg == ADDR_LAST) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_READY;
      end
    endcase
  end

  // State and sweep counter registers; reset restarts any sweep from word 0.
  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      state_reg    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  // Write-port mux: the sweep owns the array during CLEAR and external
  // requests are simply dropped; nothing is written while reset is held.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = RW0_addr;
    wr_data = RW0_wdata;
    wr_mask = RW0_wmask;
    rd_en   = 1'b0;
    if (!RW0_reset) begin
      if (state_reg == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_addr_reg;
        wr_data = '0;
        wr_mask = '1;
      end else begin
        wr_en = RW0_en && RW0_wmode;
        rd_en = RW0_en && !RW0_wmode;
      end
    end
  end

  // Array write with per-lane enables; unmasked lanes keep their old value.
  always_ff @(posedge RW0_clk) begin
    if (wr_en) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (wr_mask[i]) begin
          ram[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Registered read data: only an accepted read updates it, so it holds
  // across idles and across writes to the last-read address.
  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      rdata_reg <= '0;
    end else if (rd_en) begin
      rdata_reg <= ram[RW0_addr];
    end
  end

  assign RW0_rdata = rdata_reg;
  assign RW0_ready = (state_reg == ST_READY);

endmodule
